sw_debounce: RTL and testbench

- Input conditioner for the board slide switches; sits directly upstream of silly_kernel and drives its SW_i bus.
- Each raw switch bit is synchronised into clk_i, then debounced: a new level is accepted only after it has held for a programmed number of cycles.
- Outputs a clean, glitch-free switch word plus a one-cycle change strobe, so the kernel and its display path never see contact bounce or metastable values.

---
 rtl/sw_debounce_pkg.sv | 9 +
 rtl/sw_debounce_bit.sv | 49 ++++
 rtl/sw_debounce.sv | 58 +++++
 tb/tb_sw_debounce.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared constants for the slide-switch debouncer.
// Optional feature macro: SW_DEBOUNCE_EDGE_EN (adds per-bit rise/fall strobes).
package sw_debounce_pkg;

  localparam int unsigned SW_WIDTH            = 10;
  localparam int unsigned SW_DEBOUNCE_DEFAULT = 50000;
  localparam int unsigned SW_SYNC_DEFAULT     = 2;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchroniser chain, stability counter and accepted-level flop.
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
  parameter int unsigned SYNC_STAGES     = SW_SYNC_DEFAULT,
  parameter logic        RESET_VAL       = 1'b0
) (
  input  logic clk_i,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic accept_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  // Plain flop chain; nothing between stages so each stage gets a full cycle to resolve.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], raw};
  end

  // High in the cycle whose edge will load the new level.
  assign accept_c = (s != level) && (cnt == CNT_LAST);

  // Any sample matching the accepted level restarts the count.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      level <= RESET_VAL;
    end else if (s == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= s;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: per-bit synchronise + debounce, with a change strobe.
// SW_DEBOUNCE_EDGE_EN adds registered per-bit rise/fall strobes.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned      WIDTH           = SW_WIDTH,
  parameter int unsigned      DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
  parameter int unsigned      SYNC_STAGES     = SW_SYNC_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic             sw_changed_o
`ifdef SW_DEBOUNCE_EDGE_EN
  ,
  output logic [WIDTH-1:0] sw_rise_o,
  output logic [WIDTH-1:0] sw_fall_o
`endif
);

  logic [WIDTH-1:0] accept_c;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .RESET_VAL       (RESET_VAL[gi])
    ) u_bit (
      .clk_i    (clk_i),
      .reset    (reset),
      .raw      (sw_raw_i[gi]),
      .level    (sw_o[gi]),
      .accept_c (accept_c[gi])
    );
  end

  // Registered alongside the level flops so the strobe lands with the new sw_o.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) sw_changed_o <= 1'b0;
    else        sw_changed_o <= |accept_c;
  end

`ifdef SW_DEBOUNCE_EDGE_EN
  // An accepted bit always flips, so its current level tells the direction.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      sw_rise_o <= '0;
      sw_fall_o <= '0;
    end else begin
      sw_rise_o <= accept_c & ~sw_o;
      sw_fall_o <= accept_c &  sw_o;
    end
  end
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce (DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
// Directed scenarios plus random bouncing input against a sliding-window reference.
module tb_sw_debounce;

  localparam int unsigned W = 10;
  localparam int unsigned D = 4;
  localparam int unsigned S = 2;

  logic         clk_i = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] sw_raw_i = '0;
  logic [W-1:0] sw_o;
  logic         sw_changed_o;
`ifdef SW_DEBOUNCE_EDGE_EN
  logic [W-1:0] sw_rise_o;
  logic [W-1:0] sw_fall_o;
`endif

  int total = 0;
  int bad   = 0;

  sw_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D),
    .SYNC_STAGES     (S),
    .RESET_VAL       ('0)
  ) dut (
    .clk_i        (clk_i),
    .reset        (reset),
    .sw_raw_i     (sw_raw_i),
    .sw_o         (sw_o),
    .sw_changed_o (sw_changed_o)
`ifdef SW_DEBOUNCE_EDGE_EN
    ,
    .sw_rise_o    (sw_rise_o),
    .sw_fall_o    (sw_fall_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Reference: a bit flips once the last D synchronised samples (all taken
  // since reset) disagree with the accepted level.
  logic [W-1:0] pipe [S];
  logic [W-1:0] hist [D];
  int           n_since;
  logic [W-1:0] exp_out, exp_rise, exp_fall;
  logic         exp_chg;

  always @(posedge clk_i or negedge reset) begin
    logic [W-1:0] new_out;
    logic         all_diff;
    if (!reset) begin
      for (int j = 0; j < S; j++) pipe[j] = '0;
      for (int j = 0; j < D; j++) hist[j] = '0;
      n_since  = 0;
      exp_out  = '0;
      exp_chg  = 1'b0;
      exp_rise = '0;
      exp_fall = '0;
    end else begin
      for (int j = D - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = pipe[S-1];
      if (n_since < D) n_since++;
      new_out = exp_out;
      if (n_since >= D) begin
        for (int b = 0; b < W; b++) begin
          all_diff = 1'b1;
          for (int j = 0; j < D; j++) if (hist[j][b] == exp_out[b]) all_diff = 1'b0;
          if (all_diff) new_out[b] = ~exp_out[b];
        end
      end
      exp_chg  = (new_out != exp_out);
      exp_rise = new_out & ~exp_out;
      exp_fall = exp_out & ~new_out;
      exp_out  = new_out;
      for (int j = S - 1; j > 0; j--) pipe[j] = pipe[j-1];
      pipe[0] = sw_raw_i;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    int edge_at = -1;
    int pulses = 0;
    reset = 1'b0;
    sw_raw_i = 10'h3FF;
    repeat (3) tick();
    total++;
    if (sw_o !== 10'h000) begin bad++; $display("FAIL reset_sw_o got=%h want=%h", sw_o, 10'h000); end
    total++;
    if (sw_changed_o !== 1'b0) begin bad++; $display("FAIL reset_changed got=%b want=0", sw_changed_o); end
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (sw_changed_o === 1'b1) pulses++;
      if (edge_at < 0 && sw_o === 10'h3FF) edge_at = k;
    end
    total++;
    if (edge_at != 6) begin bad++; $display("FAIL reset_release_latency got=%0d want=6", edge_at); end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL reset_release_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_clean_step();
    int edge_at = -1;
    int pulses = 0;
    logic [W-1:0] rise_seen = '0;
    sw_raw_i = '0;
    repeat (10) tick();
    sw_raw_i = 10'b0000110010;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (sw_changed_o === 1'b1) begin
        pulses++;
`ifdef SW_DEBOUNCE_EDGE_EN
        rise_seen = sw_rise_o;
`endif
      end
      if (edge_at < 0 && sw_o === 10'b0000110010) edge_at = k;
    end
    total++;
    if (edge_at != 6) begin bad++; $display("FAIL clean_latency got=%0d want=6", edge_at); end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL clean_pulses got=%0d want=1", pulses); end
`ifdef SW_DEBOUNCE_EDGE_EN
    total++;
    if (rise_seen !== 10'b0000110010) begin bad++; $display("FAIL clean_rise got=%b want=%b", rise_seen, 10'b0000110010); end
`else
    rise_seen = '0;
`endif
  endtask

  task automatic test_bounce();
    int edge_at = -1;
    int pulses = 0;
    logic early = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sw_raw_i[0] = (k % 2 == 0);
      tick();
      if (sw_o[0] !== 1'b0) early = 1'b1;
    end
    sw_raw_i[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (sw_changed_o === 1'b1) pulses++;
      if (edge_at < 0 && sw_o[0] === 1'b1) edge_at = k;
    end
    total++;
    if (early !== 1'b0) begin bad++; $display("FAIL bounce_held_low got=%b want=0", early); end
    total++;
    if (edge_at != 6) begin bad++; $display("FAIL bounce_latency got=%0d want=6", edge_at); end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL bounce_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_glitch();
    logic moved = 1'b0;
    int pulses = 0;
    sw_raw_i = '0;
    repeat (10) tick();
    sw_raw_i[5] = 1'b1;
    repeat (3) tick();
    sw_raw_i[5] = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (sw_o[5] !== 1'b0) moved = 1'b1;
      if (sw_changed_o !== 1'b0) pulses++;
    end
    total++;
    if (moved !== 1'b0) begin bad++; $display("FAIL glitch_sw5 got=%b want=0", moved); end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL glitch_pulses got=%0d want=0", pulses); end
  endtask

  task automatic test_staggered();
    int e1 = -1;
    int e2 = -1;
    int pulses = 0;
    sw_raw_i = 10'b0000000010;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) sw_raw_i = 10'b0000000110;
      if (sw_changed_o === 1'b1) pulses++;
      if (e1 < 0 && sw_o[1] === 1'b1) e1 = k;
      if (e2 < 0 && sw_o[2] === 1'b1) e2 = k;
    end
    total++;
    if (e1 != 6) begin bad++; $display("FAIL stagger_bit1 got=%0d want=6", e1); end
    total++;
    if (e2 != 7) begin bad++; $display("FAIL stagger_bit2 got=%0d want=7", e2); end
    total++;
    if (pulses != 2) begin bad++; $display("FAIL stagger_pulses got=%0d want=2", pulses); end
  endtask

  task automatic test_reset_mid();
    int edge_at = -1;
    int pulses = 0;
    sw_raw_i = '0;
    repeat (10) tick();
    sw_raw_i[3] = 1'b1;
    repeat (4) tick();
    total++;
    if (sw_o[3] !== 1'b0) begin bad++; $display("FAIL midreset_pre got=%b want=0", sw_o[3]); end
    reset = 1'b0;
    tick();
    total++;
    if (sw_o !== 10'h000 || sw_changed_o !== 1'b0) begin
      bad++; $display("FAIL midreset_in_reset got=%h/%b want=000/0", sw_o, sw_changed_o);
    end
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (sw_changed_o === 1'b1) pulses++;
      if (edge_at < 0 && sw_o[3] === 1'b1) edge_at = k;
    end
    total++;
    if (edge_at != 6) begin bad++; $display("FAIL midreset_latency got=%0d want=6", edge_at); end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL midreset_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_random();
    int changes = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < W; b++) if ($urandom_range(4, 0) == 0) sw_raw_i[b] = ~sw_raw_i[b];
      if ($urandom_range(599, 0) == 0) reset = 1'b0;
      else reset = 1'b1;
      tick();
      if (exp_chg) changes++;
      total++;
      if (sw_o !== exp_out) begin bad++; $display("FAIL rand_sw_o cyc=%0d got=%h want=%h", c, sw_o, exp_out); end
      total++;
      if (sw_changed_o !== exp_chg) begin bad++; $display("FAIL rand_changed cyc=%0d got=%b want=%b", c, sw_changed_o, exp_chg); end
`ifdef SW_DEBOUNCE_EDGE_EN
      total++;
      if (sw_rise_o !== exp_rise || sw_fall_o !== exp_fall) begin
        bad++; $display("FAIL rand_edges cyc=%0d got=%h/%h want=%h/%h", c, sw_rise_o, sw_fall_o, exp_rise, exp_fall);
      end
`endif
    end
    reset = 1'b1;
    total++;
    if (changes < 20) begin bad++; $display("FAIL rand_activity got=%0d want>=20", changes); end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_bounce();
    test_glitch();
    test_staggered();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
